// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment encoder and capture decoder.
//   char_t      - 2-bit character code (d, E, 1, blank)
//   SEG_*       - active-low segment patterns, bit 0 = a ... bit 6 = g
//   cap_state_t - capture tracking state
package seg7_pkg;

  typedef enum logic [1:0] {
    CH_D     = 2'b00,
    CH_E     = 2'b01,
    CH_ONE   = 2'b10,
    CH_BLANK = 2'b11
  } char_t;

  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_ONE   = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_HELD
  } cap_state_t;

endpackage

// File: rtl/seg_to_char.sv
// seg_to_char: combinational reverse lookup of an active-low segment pattern.
//   seg_n - 7-bit active-low pattern
//   code  - decoded character code (CH_BLANK when unmatched)
//   match - high when seg_n is one of the four known patterns
module seg_to_char
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output char_t      code,
  output logic       match
);

  always_comb begin
    code  = CH_BLANK;
    match = 1'b1;
    case (seg_n)
      SEG_D:     code = CH_D;
      SEG_E:     code = CH_E;
      SEG_ONE:   code = CH_ONE;
      SEG_BLANK: code = CH_BLANK;
      default:   match = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: samples a multiplexed active-low 7-segment bus,
// requires STABLE_CYCLES identical (digit, pattern) samples, then decodes the
// pattern into a 2-bit code held per digit.
//   clk, reset  - clock, synchronous active-high reset
//   seg_n       - active-low segment lines
//   dig_sel_n   - active-low digit selects (valid when exactly one low)
//   chars       - decoded codes, digit i at [2i+1:2i]
//   char_valid  - per-digit decoded-value flag
//   frame_valid - one-cycle pulse when every digit captured since last pulse
//   err         - one-cycle pulse on capture of an unknown pattern
//   err_digit   - digit index of the last err
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     dig_sel_n,
  output logic [2*NUM_DIGITS-1:0]   chars,
  output logic [NUM_DIGITS-1:0]     char_valid,
  output logic                      frame_valid,
  output logic                      err,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] err_digit
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(STABLE_CYCLES);

  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_sel;
  logic [6:0]            trk_seg;
  logic [IW-1:0]         trk_idx;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         nxt_cnt;
  cap_state_t            state;

  logic                  sel_valid;
  logic [IW-1:0]         sel_idx;
  logic                  same_pair;
  logic                  do_cap;
  char_t                 dec_code;
  logic                  dec_match;

  logic [NUM_DIGITS-1:0][1:0] bank;
  logic [NUM_DIGITS-1:0]      seen;
  logic [NUM_DIGITS-1:0]      seen_nxt;

  assign chars = bank;

  seg_to_char u_dec (
    .seg_n (s_seg),
    .code  (dec_code),
    .match (dec_match)
  );

  always_comb begin
    sel_valid = ($countones(~s_sel) == 1);
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!s_sel[i]) sel_idx = IW'(i);
    end
  end

  assign same_pair = (sel_idx == trk_idx) && (s_seg == trk_seg);

  // A new pair always starts at cnt = 1, so STABLE_CYCLES = 1 captures
  // immediately; HELD with an unchanged pair never advances the count.
  always_comb begin
    nxt_cnt = cnt;
    do_cap  = 1'b0;
    if (sel_valid) begin
      if (state == ST_IDLE || !same_pair) begin
        nxt_cnt = CW'(1);
        do_cap  = (CNT_TARGET == CW'(1));
      end else if (state == ST_TRACK) begin
        nxt_cnt = (cnt == '1) ? cnt : cnt + CW'(1);
        do_cap  = (nxt_cnt == CNT_TARGET);
      end
    end
  end

  always_comb begin
    seen_nxt          = seen;
    seen_nxt[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg       <= '1;
      s_sel       <= '1;
      trk_seg     <= '1;
      trk_idx     <= '0;
      cnt         <= '0;
      state       <= ST_IDLE;
      bank        <= '1;
      char_valid  <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_digit   <= '0;
    end else begin
      s_seg       <= seg_n;
      s_sel       <= dig_sel_n;
      frame_valid <= 1'b0;
      err         <= 1'b0;

      if (!sel_valid) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        trk_idx <= sel_idx;
        trk_seg <= s_seg;
        cnt     <= nxt_cnt;
        if (do_cap || (state == ST_HELD && same_pair)) state <= ST_HELD;
        else                                          state <= ST_TRACK;
      end

      if (do_cap) begin
        if (dec_match) begin
          bank[sel_idx]       <= dec_code;
          char_valid[sel_idx] <= 1'b1;
          if (&seen_nxt) begin
            frame_valid <= 1'b1;
            seen        <= '0;
          end else begin
            seen <= seen_nxt;
          end
        end else begin
          char_valid[sel_idx] <= 1'b0;
          err                 <= 1'b1;
          err_digit           <= sel_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Testbench for seg7_capture_decoder: directed scenarios followed by random
// segments, compared every cycle against a run-length reference model.
module tb_seg7_capture_decoder;

  localparam int N = 4;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [6:0]     seg_n;
  logic [N-1:0]   dig_sel_n;
  logic [2*N-1:0] chars;
  logic [N-1:0]   char_valid;
  logic           frame_valid;
  logic           err;
  logic [1:0]     err_digit;

  seg7_capture_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
    .chars       (chars),
    .char_valid  (char_valid),
    .frame_valid (frame_valid),
    .err         (err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       hit;
    int       digit;
    bit [6:0] pat;
  } ev_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2*N-1:0] exp_chars;
  logic [N-1:0]   exp_cv;
  logic           exp_frame;
  logic           exp_err;
  logic [1:0]     exp_edig;
  bit             seen_m[N];
  int             run_len;
  int             last_dig;
  bit [6:0]       last_pat;
  ev_t            d1, d2;
  int             frames_seen;

  function automatic bit decode(input bit [6:0] p, output bit [1:0] c);
    c = 2'b11;
    case (p)
      7'h21: begin c = 2'b00; return 1'b1; end
      7'h06: begin c = 2'b01; return 1'b1; end
      7'h79: begin c = 2'b10; return 1'b1; end
      7'h7F: begin c = 2'b11; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sel_digit(input logic [N-1:0] sel);
    int cnt = 0;
    int d = -1;
    for (int i = 0; i < N; i++) if (sel[i] === 1'b0) begin cnt++; d = i; end
    return (cnt == 1) ? d : -1;
  endfunction

  task automatic model_reset();
    exp_chars = '1;
    exp_cv    = '0;
    exp_frame = 1'b0;
    exp_err   = 1'b0;
    exp_edig  = '0;
    for (int i = 0; i < N; i++) seen_m[i] = 1'b0;
    run_len   = 0;
    last_dig  = -1;
    last_pat  = '0;
    d1 = '{hit: 1'b0, digit: 0, pat: '0};
    d2 = '{hit: 1'b0, digit: 0, pat: '0};
  endtask

  task automatic model_apply(input ev_t e);
    bit [1:0] c;
    bit all;
    exp_frame = 1'b0;
    exp_err   = 1'b0;
    if (!e.hit) return;
    if (decode(e.pat, c)) begin
      exp_chars[2*e.digit +: 2] = c;
      exp_cv[e.digit] = 1'b1;
      seen_m[e.digit] = 1'b1;
      all = 1'b1;
      for (int i = 0; i < N; i++) all &= seen_m[i];
      if (all) begin
        exp_frame = 1'b1;
        for (int i = 0; i < N; i++) seen_m[i] = 1'b0;
      end
    end else begin
      exp_cv[e.digit] = 1'b0;
      exp_err  = 1'b1;
      exp_edig = 2'(e.digit);
    end
  endtask

  task automatic check_outputs();
    checks++;
    assert (chars === exp_chars) else begin
      errors++; $error("FAIL chars got %h exp %h at %0t", chars, exp_chars, $time);
    end
    checks++;
    assert (char_valid === exp_cv) else begin
      errors++; $error("FAIL char_valid got %b exp %b at %0t", char_valid, exp_cv, $time);
    end
    checks++;
    assert (frame_valid === exp_frame) else begin
      errors++; $error("FAIL frame_valid got %b exp %b at %0t", frame_valid, exp_frame, $time);
    end
    checks++;
    assert (err === exp_err) else begin
      errors++; $error("FAIL err got %b exp %b at %0t", err, exp_err, $time);
    end
    checks++;
    assert (err_digit === exp_edig) else begin
      errors++; $error("FAIL err_digit got %0d exp %0d at %0t", err_digit, exp_edig, $time);
    end
    if (frame_valid === 1'b1) frames_seen++;
  endtask

  // One clock cycle: entered #1 after a rising edge, leaves at the same point
  // of the next cycle. A capture-worthy run seen in driven cycle n shows up
  // on the outputs in cycle n+2.
  task automatic cycle(input bit rst, input logic [N-1:0] sel, input logic [6:0] seg);
    ev_t e;
    int d;
    model_apply(d2);
    d2 = d1;
    reset = rst;
    dig_sel_n = sel;
    seg_n = seg;
    d = sel_digit(sel);
    e = '{hit: 1'b0, digit: 0, pat: '0};
    if (rst || d < 0) begin
      run_len = 0;
      last_dig = -1;
    end else begin
      if (d == last_dig && seg == last_pat) run_len++;
      else run_len = 1;
      last_dig = d;
      last_pat = seg;
      if (run_len == S) e = '{hit: 1'b1, digit: d, pat: seg};
    end
    d1 = e;
    @(negedge clk);
    check_outputs();
    if (rst) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [N-1:0] sel, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, sel, seg);
  endtask

  function automatic logic [N-1:0] dsel(input int d);
    logic [N-1:0] s = '1;
    s[d] = 1'b0;
    return s;
  endfunction

  initial begin
    int f0;
    logic [6:0] pats [5];
    pats[0] = 7'h21; pats[1] = 7'h06; pats[2] = 7'h79; pats[3] = 7'h7F; pats[4] = 7'h00;
    frames_seen = 0;
    model_reset();
    reset = 1'b1;
    dig_sel_n = '1;
    seg_n = '1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_outputs();   // reset state
    @(posedge clk);
    #1;

    // 1: full scan, one frame
    f0 = frames_seen;
    hold(dsel(0), 7'h21, 6);
    hold(dsel(1), 7'h06, 6);
    hold(dsel(2), 7'h79, 6);
    hold(dsel(3), 7'h7F, 6);
    hold('1, '1, 2);
    checks++;
    assert (chars === 8'b11_10_01_00 && char_valid === 4'hF) else begin
      errors++; $error("FAIL scan1 got %h/%h exp e4/f", chars, char_valid);
    end
    checks++;
    assert (frames_seen - f0 == 1) else begin
      errors++; $error("FAIL frame_count1 got %0d exp 1", frames_seen - f0);
    end

    // 2: short E then d on digit 1
    hold(dsel(1), 7'h06, 3);
    hold(dsel(1), 7'h21, 4);
    hold('1, '1, 3);

    // 3: invalid pattern on digit 2
    hold(dsel(2), 7'h00, 4);
    hold('1, '1, 3);

    // 4: two selects low, then digit 0
    hold(4'b1100, 7'h79, 10);
    hold(4'b1110, 7'h79, 4);
    hold('1, '1, 3);

    // 5: long hold, one gap, re-capture
    hold(dsel(0), 7'h79, 20);
    hold('1, '1, 1);
    hold(dsel(0), 7'h79, 4);
    hold('1, '1, 3);

    // 6: reset mid-scan, then a clean scan gives exactly one frame
    hold(dsel(0), 7'h21, 5);
    hold(dsel(1), 7'h06, 5);
    hold(dsel(2), 7'h79, 3);
    cycle(1'b1, dsel(2), 7'h79);
    hold(dsel(2), 7'h79, 1);
    hold('1, '1, 2);
    f0 = frames_seen;
    for (int d = 0; d < N; d++) hold(dsel(d), 7'h7F, 5);
    hold('1, '1, 3);
    checks++;
    assert (frames_seen - f0 == 1) else begin
      errors++; $error("FAIL frame_count6 got %0d exp 1", frames_seen - f0);
    end

    // random segments
    for (int k = 0; k < 120; k++) begin
      logic [N-1:0] s;
      int r = $urandom_range(0, 9);
      if (r < 7)       s = dsel($urandom_range(0, N-1));
      else if (r == 7) s = '1;
      else             s = N'($urandom);
      if ($urandom_range(0, 20) == 0)
        cycle(1'b1, s, pats[$urandom_range(0, 4)]);
      else
        hold(s, pats[$urandom_range(0, 4)], $urandom_range(1, 7));
    end
    hold('1, '1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_capture_decoder.md
# seg7_capture_decoder

Receive-side counterpart of the character-to-7-segment encoder. Passively samples a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit select), filters scan glitches, and decodes each digit's segment pattern back into the 2-bit character code. The recovered codes go to a register bank. A frame pulse fires when every digit has been captured once. Used as a loop-back checker on the display path and as a self-test monitor in the lab top level.

## Interface

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; must be ≥ 1.
- STABLE_CYCLES, 4: consecutive identical samples required before capture; must be ≥ 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_n  in  7  segment lines, active-low, bit 0 = segment a … bit 6 = segment g.
- dig_sel_n  in  NUM_DIGITS  digit selects, active-low; a valid scan slot has exactly one bit low.
- chars  out  2*NUM_DIGITS  decoded codes; digit i occupies bits [2i+1:2i].
- char_valid  out  NUM_DIGITS  bit i set when chars for digit i holds a decoded value.
- frame_valid  out  1  one-cycle pulse when all digits have been captured since the last pulse.
- err  out  1  one-cycle pulse on capture of an unrecognised pattern.
- err_digit  out  $clog2(NUM_DIGITS) (min 1)  index of the digit for the last err; held until the next err.

## Operation

Decode map (seg_n[6:0] → code):
- 7'h21 → 2'b00 'd'
- 7'h06 → 2'b01 'E'
- 7'h79 → 2'b10 '1'
- 7'h7F → 2'b11 blank
- Any other pattern is invalid.

Input sampling:
- seg_n and dig_sel_n are registered every cycle; no synchroniser.
- Sample pair = (digit index, pattern). The digit index is valid only if dig_sel_n is one-hot-low.

State machine:
- IDLE: no valid digit selected. Stays in IDLE while the select is not one-hot-low (all high, or multiple low). On a valid pair, go to TRACK with cnt = 1.
- TRACK: the pair equals the previous sample → cnt increments. When cnt reaches STABLE_CYCLES, perform a capture and go to HELD. A different valid pair restarts TRACK with cnt = 1. An invalid select goes to IDLE.
- HELD: capture done for the current pair; no re-capture while the pair is unchanged. A different valid pair goes to TRACK with cnt = 1. An invalid select goes to IDLE.
- cnt is saturating, width $clog2(STABLE_CYCLES+1).

Capture of digit i:
- Valid pattern: chars[i] ← code; char_valid[i] ← 1; seen[i] ← 1.
- Invalid pattern: chars[i] unchanged; char_valid[i] ← 0; seen[i] unchanged; err pulses; err_digit ← i.

Frame:
- When a capture makes the internal seen mask all-ones, frame_valid pulses and seen clears in the same cycle.
- Captures of a digit already in seen update chars but do not affect frame.

Reset values:
- chars all 2'b11, char_valid 0, frame_valid 0, err 0, err_digit 0.
- Internally: seen 0, cnt 0, state IDLE.
- Reset mid-scan discards partial counts and the seen mask. A capture pending in the reset cycle does not occur.

## Timing

- A pair first driven in cycle t and held is captured by the edge ending cycle t+STABLE_CYCLES. chars, char_valid, err and frame_valid are visible in cycle t+STABLE_CYCLES+1.
- If the pair is held for fewer than STABLE_CYCLES cycles, there is no capture and no output change.
- frame_valid and err are each exactly one cycle wide. Both may assert in separate cycles only, since one capture occurs per cycle at most.
- Holding a pair indefinitely produces exactly one capture. Re-capture requires a change of pair or a pass through IDLE.
- All outputs are registered; there is no combinational input-to-output path.

## Structure

- Package seg7_pkg holds:
  - typedef enum logic [1:0] char_t: CH_D, CH_E, CH_ONE, CH_BLANK.
  - localparams SEG_D, SEG_E, SEG_ONE, SEG_BLANK (the active-low patterns above).
  - The capture state enum.
- The encoder and this block both import seg7_pkg.
- One combinational sub-module, seg_to_char: input a 7-bit pattern; outputs a 2-bit code and a match flag.
- Top-level RTL contains the input registers, one-hot check/index encode, FSM, counter, register bank and seen mask.

## Test plan

1. Reset, NUM_DIGITS=4, STABLE_CYCLES=4; scan digits 0..3 with 7'h21, 7'h06, 7'h79, 7'h7F, each held 6 cycles → chars = {2'b11, 2'b10, 2'b01, 2'b00}, char_valid = 4'hF, one frame_valid pulse 5 cycles after digit 3 first driven.
2. Digit 1 driven with 7'h06 for 3 cycles, then 7'h21 for 4 cycles → only 'd' captured, 5 cycles after 7'h21 first driven; no capture of 'E'.
3. Digit 2 with 7'h00 held 4 cycles → err pulse, err_digit = 2, char_valid[2] = 0, chars[2] unchanged, no frame_valid.
4. dig_sel_n = 4'b1100 (two low) held 10 cycles → no capture, no err. Then dig_sel_n = 4'b1110 held 4 cycles → digit 0 captured.
5. Hold digit 0 with 7'h79 for 20 cycles → exactly one capture. Insert one all-high select cycle, then re-apply for 4 cycles → second capture.
6. Assert reset during a partially completed scan (digits 0, 1 captured) → all outputs return to reset values. The next full scan gives exactly one frame_valid.
